// File: rtl/morse_char_assembler_pkg.sv
// Shared types and constants for the Morse character assembler.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT_CHAR,
    ST_EMIT_SPACE
  } state_e;

  typedef logic [7:0] ascii_t;

  localparam ascii_t SPACE_CHAR       = 8'h20;
  localparam ascii_t UNKNOWN_CHAR_DEF = 8'h3F;

  // Symbol counter width; holds letters of up to 7 symbols.
  localparam int CNT_W = 3;

endpackage

// File: rtl/morse_char_assembler_if.sv
// Character stream towards the UART/display sink (valid/ready).
interface morse_char_assembler_if;
  import morse_pkg::*;

  ascii_t char_data;
  logic   char_valid;
  logic   char_ready;

  modport master (output char_data, output char_valid, input char_ready);
  modport slave  (input char_data, input char_valid, output char_ready);

endinterface

// File: rtl/morse_char_assembler_lookup.sv
// Combinational Morse pattern to ASCII translation (dot=0, dash=1, first symbol in MSB).
module morse_lookup
  import morse_pkg::*;
#(
  parameter int     PAT_W        = 6,
  parameter ascii_t UNKNOWN_CHAR = UNKNOWN_CHAR_DEF
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic             over_i,
  output ascii_t           char_o
);

  logic [5:0] p6;
  logic [8:0] key;

  always_comb begin
    p6  = 6'(pat_i);
    key = {cnt_i, p6};
    case (key)
      {3'd2, 6'b000001}: char_o = 8'h41; // A
      {3'd4, 6'b001000}: char_o = 8'h42;
      {3'd4, 6'b001010}: char_o = 8'h43;
      {3'd3, 6'b000100}: char_o = 8'h44;
      {3'd1, 6'b000000}: char_o = 8'h45;
      {3'd4, 6'b000010}: char_o = 8'h46;
      {3'd3, 6'b000110}: char_o = 8'h47;
      {3'd4, 6'b000000}: char_o = 8'h48;
      {3'd2, 6'b000000}: char_o = 8'h49;
      {3'd4, 6'b000111}: char_o = 8'h4A;
      {3'd3, 6'b000101}: char_o = 8'h4B;
      {3'd4, 6'b000100}: char_o = 8'h4C;
      {3'd2, 6'b000011}: char_o = 8'h4D;
      {3'd2, 6'b000010}: char_o = 8'h4E;
      {3'd3, 6'b000111}: char_o = 8'h4F;
      {3'd4, 6'b000110}: char_o = 8'h50;
      {3'd4, 6'b001101}: char_o = 8'h51;
      {3'd3, 6'b000010}: char_o = 8'h52;
      {3'd3, 6'b000000}: char_o = 8'h53;
      {3'd1, 6'b000001}: char_o = 8'h54;
      {3'd3, 6'b000001}: char_o = 8'h55;
      {3'd4, 6'b000001}: char_o = 8'h56;
      {3'd3, 6'b000011}: char_o = 8'h57;
      {3'd4, 6'b001001}: char_o = 8'h58;
      {3'd4, 6'b001011}: char_o = 8'h59;
      {3'd4, 6'b001100}: char_o = 8'h5A; // Z
      {3'd5, 6'b011111}: char_o = 8'h30; // 0
      {3'd5, 6'b001111}: char_o = 8'h31;
      {3'd5, 6'b000111}: char_o = 8'h32;
      {3'd5, 6'b000011}: char_o = 8'h33;
      {3'd5, 6'b000001}: char_o = 8'h34;
      {3'd5, 6'b000000}: char_o = 8'h35;
      {3'd5, 6'b010000}: char_o = 8'h36;
      {3'd5, 6'b011000}: char_o = 8'h37;
      {3'd5, 6'b011100}: char_o = 8'h38;
      {3'd5, 6'b011110}: char_o = 8'h39; // 9
      {3'd6, 6'b010101}: char_o = 8'h2E; // '.'
      {3'd6, 6'b110011}: char_o = 8'h2C; // ','
      {3'd6, 6'b001100}: char_o = 8'h3F; // '?'
      default:           char_o = UNKNOWN_CHAR;
    endcase
    if (over_i) char_o = UNKNOWN_CHAR;
  end

endmodule

// File: rtl/morse_char_assembler.sv
// Collects dot/dash pulses into letters, emits ASCII (plus word spaces) into a FWFT FIFO.
module morse_char_assembler
  import morse_pkg::*;
#(
  parameter int     FIFO_DEPTH   = 4,
  parameter int     MAX_SYMBOLS  = 6,
  parameter ascii_t UNKNOWN_CHAR = UNKNOWN_CHAR_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          dot,
  input  logic                          dash,
  input  logic                          lg,
  input  logic                          wg,
  input  logic                          clr_err,
  morse_char_assembler_if.master        char_if,
  output logic                          overflow,
  output logic                          sym_err,
  output logic                          busy
);

  localparam int               AW       = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_SYMBOLS);
  localparam logic [AW:0]      FULL_OCC = (AW+1)'(FIFO_DEPTH);

  state_e                 state_q, rest_st;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_base, snap_cnt_q;
  logic [MAX_SYMBOLS-1:0] pat_q, pat_d, pat_base, snap_pat_q;
  logic                   over_q, over_d, over_base, snap_over_q;
  logic                   space_pend_q, last_space_q;
  logic                   overflow_q, sym_err_q;
  ascii_t                 mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            occ_q;

  logic   emitting, letter_take, space_only, sym_ev;
  logic   push, pop, full, push_acc, drop;
  ascii_t push_data, lookup_char;

  // A gap clears the collector in the same cycle, so a coincident symbol starts the next letter.
  always_comb begin
    emitting    = (state_q == ST_EMIT_CHAR) || (state_q == ST_EMIT_SPACE);
    letter_take = (lg | wg) && !emitting && (cnt_q != '0);
    space_only  = wg && !emitting && (cnt_q == '0) && !last_space_q;
    cnt_base    = letter_take ? '0   : cnt_q;
    pat_base    = letter_take ? '0   : pat_q;
    over_base   = letter_take ? 1'b0 : over_q;
    cnt_d       = cnt_base;
    pat_d       = pat_base;
    over_d      = over_base;
    sym_ev      = dot & dash;
    if (dot ^ dash) begin
      if (cnt_base == MAX_CNT) begin
        over_d = 1'b1;
        sym_ev = 1'b1;
      end else begin
        cnt_d = cnt_base + CNT_W'(1);
        pat_d = {pat_base[MAX_SYMBOLS-2:0], dash};
      end
    end
    rest_st = (cnt_d != '0) ? ST_COLLECT : ST_IDLE;
  end

  always_comb begin
    full      = (occ_q == FULL_OCC);
    pop       = (occ_q != '0) && char_if.char_ready;
    push      = emitting;
    push_data = (state_q == ST_EMIT_CHAR) ? lookup_char : SPACE_CHAR;
    push_acc  = push && (!full || pop);
    drop      = push && full && !pop;
  end

  morse_lookup #(
    .PAT_W        (MAX_SYMBOLS),
    .UNKNOWN_CHAR (UNKNOWN_CHAR)
  ) u_lookup (
    .cnt_i  (snap_cnt_q),
    .pat_i  (snap_pat_q),
    .over_i (snap_over_q),
    .char_o (lookup_char)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pat_q        <= '0;
      over_q       <= 1'b0;
      space_pend_q <= 1'b0;
      last_space_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
      over_q <= over_d;
      case (state_q)
        ST_EMIT_CHAR: begin
          last_space_q <= 1'b0;
          space_pend_q <= 1'b0;
          state_q      <= space_pend_q ? ST_EMIT_SPACE : rest_st;
        end
        ST_EMIT_SPACE: begin
          last_space_q <= 1'b1;
          state_q      <= rest_st;
        end
        default: begin
          if (letter_take) begin
            state_q      <= ST_EMIT_CHAR;
            space_pend_q <= wg;
          end else if (space_only) begin
            state_q <= ST_EMIT_SPACE;
          end else begin
            state_q <= rest_st;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
      sym_err_q  <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_acc && !pop)      occ_q <= occ_q + (AW+1)'(1);
      else if (!push_acc && pop) occ_q <= occ_q - (AW+1)'(1);
      overflow_q <= (overflow_q & ~clr_err) | drop;
      sym_err_q  <= (sym_err_q & ~clr_err) | sym_ev;
    end
  end

  // Datapath storage carries no reset; it is only read once the control marks it valid.
  always_ff @(posedge clk) begin
    if (letter_take) begin
      snap_cnt_q  <= cnt_q;
      snap_pat_q  <= pat_q;
      snap_over_q <= over_q;
    end
    if (push_acc) mem_q[wr_ptr_q] <= push_data;
  end

  assign char_if.char_valid = (occ_q != '0);
  assign char_if.char_data  = (occ_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign overflow           = overflow_q;
  assign sym_err            = sym_err_q;
  assign busy               = (cnt_q != '0) || emitting;

endmodule

// File: tb/tb_morse_char_assembler.sv
// Directed bench for morse_char_assembler with hand-computed expected characters.
module tb_morse_char_assembler;

  logic clk = 1'b0;
  logic reset_n, dot, dash, lg, wg, clr_err;
  logic overflow, sym_err, busy;
  int   vectors = 0;
  int   miscompares = 0;
  int   beats;

  morse_char_assembler_if cif ();

  morse_char_assembler dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .dot      (dot),
    .dash     (dash),
    .lg       (lg),
    .wg       (wg),
    .clr_err  (clr_err),
    .char_if  (cif),
    .overflow (overflow),
    .sym_err  (sym_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic p_dot, input logic p_dash, input logic p_lg, input logic p_wg);
    dot = p_dot; dash = p_dash; lg = p_lg; wg = p_wg;
    tick;
    dot = 1'b0; dash = 1'b0; lg = 1'b0; wg = 1'b0;
    repeat (9) tick;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!cif.char_valid && n < 30) begin
      tick;
      n++;
    end
    chk({tag, "_vld"}, 8'(cif.char_valid), 8'h01);
    chk(tag, cif.char_data, exp);
    cif.char_ready = 1'b1;
    tick;
    cif.char_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; dot = 1'b0; dash = 1'b0; lg = 1'b0; wg = 1'b0; clr_err = 1'b0;
    cif.char_ready = 1'b0;
    repeat (3) tick;
    chk("rst_valid", 8'(cif.char_valid), 8'h00);
    chk("rst_data", cif.char_data, 8'h00);
    chk("rst_ovf", 8'(overflow), 8'h00);
    chk("rst_symerr", 8'(sym_err), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    reset_n = 1'b1;
    tick;

    // Leading word gap after reset is suppressed
    pulse(0, 0, 0, 1);
    chk("lead_wg_valid", 8'(cif.char_valid), 8'h00);
    chk("lead_wg_busy", 8'(busy), 8'h00);

    // "A" with the sink always ready: one beat two cycles after lg
    cif.char_ready = 1'b1;
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    chk("a_busy_collect", 8'(busy), 8'h01);
    lg = 1'b1;
    tick;
    lg = 1'b0;
    chk("a_n1_valid", 8'(cif.char_valid), 8'h00);
    chk("a_n1_busy", 8'(busy), 8'h01);
    tick;
    chk("a_n2_valid", 8'(cif.char_valid), 8'h01);
    chk("a_n2_data", cif.char_data, 8'h41);
    tick;
    chk("a_n3_valid", 8'(cif.char_valid), 8'h00);
    chk("a_n3_busy", 8'(busy), 8'h00);
    cif.char_ready = 1'b0;

    // "SOS" + word gap
    repeat (3) pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    repeat (3) pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    repeat (3) pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    pop_expect("sos_s1", 8'h53);
    pop_expect("sos_o", 8'h4F);
    pop_expect("sos_s2", 8'h53);
    pop_expect("sos_space", 8'h20);
    repeat (5) tick;
    chk("sos_no_extra", 8'(cif.char_valid), 8'h00);
    chk("sos_symerr", 8'(sym_err), 8'h00);

    // Over-long letter: 7 dots
    repeat (7) pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    pop_expect("long_char", 8'h3F);
    chk("long_symerr", 8'(sym_err), 8'h01);
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    chk("long_clr", 8'(sym_err), 8'h00);

    // "EEEEE" with the sink stalled: 4 held, 1 dropped
    chk("eeee_ovf_pre", 8'(overflow), 8'h00);
    repeat (5) begin
      pulse(1, 0, 0, 0);
      pulse(0, 0, 1, 0);
    end
    chk("eeee_valid", 8'(cif.char_valid), 8'h01);
    chk("eeee_head", cif.char_data, 8'h45);
    chk("eeee_ovf", 8'(overflow), 8'h01);
    repeat (5) tick;
    chk("eeee_hold_valid", 8'(cif.char_valid), 8'h01);
    chk("eeee_hold_data", cif.char_data, 8'h45);
    cif.char_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      if (cif.char_valid) begin
        beats++;
        chk("eeee_beat", cif.char_data, 8'h45);
      end
      tick;
    end
    cif.char_ready = 1'b0;
    chk("eeee_count", 8'(beats), 8'h04);
    chk("eeee_empty", 8'(cif.char_valid), 8'h00);

    // Reset mid-letter discards the pending dashes
    pulse(0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_busy", 8'(busy), 8'h00);
    chk("mid_rst_ovf", 8'(overflow), 8'h00);
    tick;
    reset_n = 1'b1;
    tick;
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    pop_expect("mid_rst_e", 8'h45);
    repeat (5) tick;
    chk("mid_rst_no_extra", 8'(cif.char_valid), 8'h00);

    // "T" then three word gaps: single space only
    pulse(0, 1, 0, 0);
    repeat (3) pulse(0, 0, 0, 1);
    pop_expect("t_char", 8'h54);
    pop_expect("t_space", 8'h20);
    repeat (5) tick;
    chk("t_no_extra", 8'(cif.char_valid), 8'h00);

    // Simultaneous dot and dash: ignored, error flagged
    chk("both_symerr_pre", 8'(sym_err), 8'h00);
    pulse(1, 1, 0, 0);
    chk("both_symerr", 8'(sym_err), 8'h01);
    chk("both_busy", 8'(busy), 8'h00);
    pulse(0, 0, 1, 0);
    chk("both_no_char", 8'(cif.char_valid), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/morse_char_assembler.md
Name: morse_char_assembler

Overview:
- Consumes the single-cycle dot/dash/letter-gap/word-gap pulses from morse_decoder.
- Accumulates the symbols of one letter, translates each completed letter to ASCII and inserts a space on word gaps.
- Buffers the characters in a small output FIFO with a valid/ready handshake towards the UART/display path.
- Acts as the sequencer between the Morse timing datapath and the character sink; absorbs sink stalls and reports overflow.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.
- MAX_SYMBOLS, 6, maximum dots/dashes per letter.
- UNKNOWN_CHAR, 8'h3F, code emitted for an unmatched or over-long pattern ('?').

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock, reset is asynchronous and active-low.
- dot  in  1  single-cycle pulse: dot detected.
- dash  in  1  single-cycle pulse: dash detected.
- lg  in  1  single-cycle pulse: letter gap.
- wg  in  1  single-cycle pulse: word gap.
- char_data  out  8  ASCII at FIFO head.
- char_valid  out  1  FIFO non-empty.
- char_ready  in  1  sink accepts char_data this cycle.
- clr_err  in  1  clears the sticky flags.
- overflow  out  1  sticky: a character was dropped because the FIFO was full.
- sym_err  out  1  sticky: a letter exceeded MAX_SYMBOLS, or dot and dash arrived in the same cycle.
- busy  out  1  symbols pending or an emit state is active.

Behaviour:
- Reset values: char_data=0, char_valid=0, overflow=0, sym_err=0, busy=0. FIFO empty, symbol count=0, pattern=0, last_was_space=1, state IDLE.
- Reset asserted mid-letter or mid-emit discards everything; no partial output afterwards.
- Symbol capture:
  - dot shifts 0 into the pattern LSB; dash shifts 1; count increments.
  - Example: "A" = .- gives count 2, pattern 2'b01.
  - dot and dash in the same cycle: both ignored, sym_err set.
  - Symbol arriving with count==MAX_SYMBOLS: not stored; an over-long marker is set; the letter decodes to UNKNOWN_CHAR and sym_err is set.
- States:
  - IDLE: count==0.
  - COLLECT: count>0.
  - EMIT_CHAR: push the snapshotted letter.
  - EMIT_SPACE: push 8'h20.
- Transitions:
  - lg with count>0 -> EMIT_CHAR.
  - lg with count==0 -> ignored.
  - wg with count>0 -> EMIT_CHAR, then EMIT_SPACE.
  - wg with count==0 -> EMIT_SPACE only if last_was_space==0, else ignored.
  - After a gap: -> IDLE.
  - lg and wg in the same cycle are treated as wg.
- Snapshot: on a gap, (count, pattern, over-long marker) are copied and the collector is cleared in the same cycle. A dot/dash coincident with or following a gap belongs to the next letter.
- Latency:
  - gap pulse at cycle N: letter pushed at the edge ending N+1; char_valid high in N+2 if the FIFO was empty.
  - space pushed one cycle after the letter.
  - At most one push per cycle.
- Lookup: combinational decode of (count, pattern).
  - Covers A-Z, 0-9, '.' (.-.-.-), ',' (--..--), '?' (..--..).
  - Anything else -> UNKNOWN_CHAR.
- last_was_space: set when a space is pushed, cleared when a letter is pushed. This suppresses leading and repeated spaces.
- FIFO:
  - First-word-fall-through; char_data is valid whenever char_valid is high.
  - A pop occurs when char_valid && char_ready.
  - char_data and char_valid are stable while char_ready is low.
  - Push with FIFO full and no pop in the same cycle: character dropped, overflow set.
  - Push and pop in the same cycle while full: push accepted.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
- Sticky flags: clr_err clears both. If a flag event and clr_err coincide, the flag ends up set.
- busy = (count>0) || state in {EMIT_CHAR, EMIT_SPACE}.

Decomposition:
- Shared package morse_pkg holds:
  - state encoding (IDLE/COLLECT/EMIT_CHAR/EMIT_SPACE);
  - ASCII constants SPACE_CHAR=8'h20 and UNKNOWN_CHAR default;
  - the symbol-length width constant.
- One sub-module, morse_lookup: combinational (count, pattern, over-long marker) -> 8-bit ASCII.
- FIFO and FSM stay inline.

Test Plan:
- dot, dash, lg (pulses 10 cycles apart, char_ready=1) -> single beat char_data=8'h41 two cycles after lg; busy low afterwards.
- "... --- ..." with lg between letters and wg after the last -> beats 8'h53, 8'h4F, 8'h53, 8'h20 in order, no extra space.
- 7 dots then lg -> char_data=8'h3F, sym_err=1. clr_err pulse -> sym_err=0. A leading wg after reset produces no output.
- char_ready=0, five letters "EEEEE" -> 4 entries held, char_data=8'h45 stable, overflow=1. Then char_ready=1 -> exactly 4 beats, FIFO empty.
- reset_n low after dash, dash (before lg), release, then dot, lg -> only 8'h45 output.
- wg, wg, wg after "T" -> 8'h54, 8'h20 only. dot and dash in the same cycle -> ignored, sym_err=1.
